// File: rtl/processor_pkg.sv
// processor_pkg: types and constants shared by the processor slice.
//   loader_state_t  - imem_loader FSM state encoding
//   IMEM_ADDR_WIDTH - default imem word-address width
//   HDR_BYTES       - length of the load header (word count, big-endian)
package processor_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH = 12;
  localparam int unsigned HDR_BYTES       = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four accepted bytes into a little-endian 32-bit word.
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   clear      in   restart byte counting (start of a new load)
//   accept     in   byte_in is taken this cycle
//   byte_in    in   stream byte
//   word       out  assembled word; first byte lands in [7:0]
//   word_ready out  this accept completes the word (4th byte)
module byte_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  // Right-shifting in at the top leaves the first byte at [7:0] after four.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (accept) begin
      word     <= {byte_in, word[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_ready = accept && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives a byte stream (2-byte
// big-endian word count, then little-endian 32-bit words), writes the words
// into imem starting at BASE_ADDR, and holds the core while loading.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a trailing XOR
// checksum byte checked in the CHECK state (load_error on mismatch).
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous active-low reset
//   load_start   in   begin a load (honoured in IDLE/DONE only)
//   byte_in      in   stream byte
//   byte_valid   in   byte_in valid
//   byte_ready   out  loader accepts a byte this cycle
//   imem_address out  imem write word address
//   imem_data    out  imem write data
//   imem_wren    out  imem write strobe, one cycle per word
//   cpu_hold     out  stall fetch / hold PC at BASE_ADDR
//   load_done    out  load finished; held until next load_start
//   load_error   out  checksum mismatch (0 without the checksum feature)
// ADDR_WIDTH must lie in 9..16: the header high byte supplies the bits above 7.
module imem_loader
  import processor_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned HI_BITS = ADDR_WIDTH - 8;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CHECK;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t         state_q, state_d;
  logic [HI_BITS-1:0]    hdr_hi_q;
  logic [ADDR_WIDTH-1:0] hdr_count;
  logic [ADDR_WIDTH-1:0] remaining_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  handshake;
  logic                  start_ok;
  logic                  pack_accept;
  logic                  word_ready;
  logic [31:0]           packed_word;

  // byte_ready depends on state only, so handshake has no combinational loop.
  assign handshake   = byte_valid && byte_ready;
  assign start_ok    = load_start && ((state_q == IDLE) || (state_q == DONE));
  // Only the low ADDR_WIDTH bits of the header count are kept.
  assign hdr_count   = {hdr_hi_q, byte_in};
  assign pack_accept = handshake && (state_q == DATA);

  byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .accept     (pack_accept),
    .byte_in    (byte_in),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    imem_wren  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        cpu_hold  = 1'b0;
        load_done = (state_q == DONE);
        if (load_start) state_d = HDR_HI;
      end
      HDR_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = HDR_LO;
      end
      HDR_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = (hdr_count == '0) ? END_STATE : DATA;
      end
      DATA: begin
        byte_ready = 1'b1;
        if (word_ready) state_d = WRITE;
      end
      WRITE: begin
        imem_wren = 1'b1;
        state_d   = (remaining_q == ADDR_WIDTH'(1)) ? END_STATE : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hdr_hi_q    <= '0;
      remaining_q <= '0;
      addr_q      <= BASE_ADDR;
    end else begin
      state_q <= state_d;

      if (start_ok)              addr_q <= BASE_ADDR;
      else if (state_q == WRITE) addr_q <= addr_q + ADDR_WIDTH'(1);

      if (handshake && (state_q == HDR_HI)) hdr_hi_q <= byte_in[HI_BITS-1:0];

      if (handshake && (state_q == HDR_LO)) remaining_q <= hdr_count;
      else if (state_q == WRITE)            remaining_q <= remaining_q - ADDR_WIDTH'(1);
    end
  end

  assign imem_address = addr_q;
  assign imem_data    = packed_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       error_q;

  // Header and data bytes fold into xor_q; the CHECK byte is compared instead.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else if (start_ok) begin
      xor_q   <= '0;
      error_q <= 1'b0;
    end else if (handshake) begin
      if (state_q == CHECK) error_q <= (byte_in != xor_q);
      else                  xor_q   <= xor_q ^ byte_in;
    end
  end

  assign load_error = error_q;
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. Instance a uses BASE_ADDR 0, instance b
// uses BASE_ADDR 0xFFF (address wrap); both see the same stimulus.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;

  logic        a_ready, a_wren, a_hold, a_done, a_err;
  logic [11:0] a_addr;
  logic [31:0] a_data;
  logic        b_ready, b_wren, b_hold, b_done, b_err;
  logic [11:0] b_addr;
  logic [31:0] b_data;

  int vectors = 0;
  int errors  = 0;

  logic [11:0] a_wa[$];
  logic [31:0] a_wd[$];
  logic [11:0] b_wa[$];
  logic [31:0] b_wd[$];

  imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(12'h000)) dut_a (
    .clock(clock), .reset(reset), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(a_ready), .imem_address(a_addr),
    .imem_data(a_data), .imem_wren(a_wren), .cpu_hold(a_hold),
    .load_done(a_done), .load_error(a_err));

  imem_loader #(.ADDR_WIDTH(12), .BASE_ADDR(12'hFFF)) dut_b (
    .clock(clock), .reset(reset), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(b_ready), .imem_address(b_addr),
    .imem_data(b_data), .imem_wren(b_wren), .cpu_hold(b_hold),
    .load_done(b_done), .load_error(b_err));

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (a_wren) begin a_wa.push_back(a_addr); a_wd.push_back(a_data); end
    if (b_wren) begin b_wa.push_back(b_addr); b_wd.push_back(b_data); end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  task automatic clear_logs();
    a_wa.delete(); a_wd.delete(); b_wa.delete(); b_wd.delete();
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    logic hs;
    int   n;
    byte_in    = b;
    byte_valid = 1'b1;
    hs = 1'b0;
    for (n = 0; n < 50 && !hs; n++) begin
      hs = a_ready;
      @(negedge clock);
    end
    byte_valid = 1'b0;
    if (!hs) begin
      vectors++; errors++;
      $display("FAIL send_byte_timeout: byte %02h not accepted, byte_ready=%b required 1", b, a_ready);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", a_ready); end
    vectors++; if (a_wren  !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b exp 0", a_wren); end
    vectors++; if (a_addr  !== 12'h000) begin errors++; $display("FAIL rst_addr: got %h exp 000", a_addr); end
    vectors++; if (b_addr  !== 12'hFFF) begin errors++; $display("FAIL rst_addr_b: got %h exp fff", b_addr); end
    vectors++; if (a_data  !== 32'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", a_data); end
    vectors++; if (a_hold  !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b exp 0", a_hold); end
    vectors++; if (a_done  !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", a_done); end
    vectors++; if (a_err   !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", a_err); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_two_words();
    logic [7:0] bs [10] = '{8'h00, 8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_logs();
    start_load();
    vectors++; if (a_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b exp 1", a_ready); end
    vectors++; if (a_hold  !== 1'b1) begin errors++; $display("FAIL start_hold: got %b exp 1", a_hold); end
    foreach (bs[i]) send_byte(bs[i]);
    vectors++; if (a_wren !== 1'b1) begin errors++; $display("FAIL w2_wren: got %b exp 1", a_wren); end
    vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL w2_ready_in_write: got %b exp 0", a_ready); end
    vectors++; if (a_data !== 32'h00100093) begin errors++; $display("FAIL w2_data: got %h exp 00100093", a_data); end
    @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h92);
`endif
    vectors++; if (a_done !== 1'b1) begin errors++; $display("FAIL w2_done: got %b exp 1", a_done); end
    vectors++; if (a_hold !== 1'b0) begin errors++; $display("FAIL w2_hold: got %b exp 0", a_hold); end
    vectors++; if (a_err  !== 1'b0) begin errors++; $display("FAIL w2_err: got %b exp 0", a_err); end
    vectors++;
    if (a_wa.size() !== 2) begin
      errors++; $display("FAIL w2_count: got %0d writes exp 2", a_wa.size());
    end else begin
      vectors++; if (a_wa[0] !== 12'h000 || a_wd[0] !== 32'h00000013) begin
        errors++; $display("FAIL w2_first: got %h/%h exp 000/00000013", a_wa[0], a_wd[0]); end
      vectors++; if (a_wa[1] !== 12'h001 || a_wd[1] !== 32'h00100093) begin
        errors++; $display("FAIL w2_second: got %h/%h exp 001/00100093", a_wa[1], a_wd[1]); end
    end
  endtask

  task automatic test_zero_header();
    clear_logs();
    // load_start together with a valid byte: nothing may be taken this cycle.
    byte_in = 8'h00; byte_valid = 1'b1; load_start = 1'b1;
    #1;
    vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL zh_ready_at_start: got %b exp 0", a_ready); end
    @(negedge clock);
    load_start = 1'b0; byte_valid = 1'b0;
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    vectors++; if (a_done !== 1'b1) begin errors++; $display("FAIL zh_done: got %b exp 1", a_done); end
    vectors++; if (a_hold !== 1'b0) begin errors++; $display("FAIL zh_hold: got %b exp 0", a_hold); end
    repeat (2) @(negedge clock);
    vectors++; if (a_wa.size() !== 0) begin errors++; $display("FAIL zh_writes: got %0d exp 0", a_wa.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] bs [6] = '{8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    int  idx = 0;
    int  cyc = 0;
    logic v  = 1'b1;
    logic hs;
    clear_logs();
    start_load();
    while (idx < 6 && cyc < 100) begin
      byte_in = bs[idx]; byte_valid = v;
      hs = v && a_ready;
      @(negedge clock);
      if (hs) idx++;
      v = ~v; cyc++;
    end
    byte_valid = 1'b0;
    vectors++; if (idx !== 6) begin errors++; $display("FAIL bp_bytes: got %0d accepted exp 6", idx); end
    vectors++; if (a_wren !== 1'b1) begin errors++; $display("FAIL bp_wren: got %b exp 1", a_wren); end
    vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_in_write: got %b exp 0", a_ready); end
    @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h23);
    vectors++; if (a_err !== 1'b0) begin errors++; $display("FAIL bp_err: got %b exp 0", a_err); end
`endif
    vectors++; if (a_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", a_done); end
    vectors++;
    if (a_wa.size() !== 1) begin
      errors++; $display("FAIL bp_count: got %0d writes exp 1", a_wa.size());
    end else begin
      vectors++; if (a_wa[0] !== 12'h000 || a_wd[0] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL bp_write: got %h/%h exp 000/deadbeef", a_wa[0], a_wd[0]); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] bs [10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_logs();
    start_load();
    foreach (bs[i]) send_byte(bs[i]);
    @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h8A);
    vectors++; if (b_err !== 1'b0) begin errors++; $display("FAIL wrap_err: got %b exp 0", b_err); end
`endif
    vectors++; if (b_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b exp 1", b_done); end
    vectors++;
    if (b_wa.size() !== 2) begin
      errors++; $display("FAIL wrap_count: got %0d writes exp 2", b_wa.size());
    end else begin
      vectors++; if (b_wa[0] !== 12'hFFF || b_wd[0] !== 32'h44332211) begin
        errors++; $display("FAIL wrap_first: got %h/%h exp fff/44332211", b_wa[0], b_wd[0]); end
      vectors++; if (b_wa[1] !== 12'h000 || b_wd[1] !== 32'h88776655) begin
        errors++; $display("FAIL wrap_second: got %h/%h exp 000/88776655", b_wa[1], b_wd[1]); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] bs [6] = '{8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    clear_logs();
    start_load();
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    reset = 1'b0;
    #1;
    vectors++; if (a_ready !== 1'b0) begin errors++; $display("FAIL mr_ready: got %b exp 0", a_ready); end
    vectors++; if (a_hold !== 1'b0) begin errors++; $display("FAIL mr_hold: got %b exp 0", a_hold); end
    vectors++; if (a_wren !== 1'b0) begin errors++; $display("FAIL mr_wren: got %b exp 0", a_wren); end
    vectors++; if (a_data !== 32'h0) begin errors++; $display("FAIL mr_data: got %h exp 0", a_data); end
    vectors++; if (a_addr !== 12'h000) begin errors++; $display("FAIL mr_addr: got %h exp 000", a_addr); end
    vectors++; if (a_done !== 1'b0) begin errors++; $display("FAIL mr_done: got %b exp 0", a_done); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    start_load();
    foreach (bs[i]) send_byte(bs[i]);
    @(negedge clock);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h09);
`endif
    vectors++; if (a_done !== 1'b1) begin errors++; $display("FAIL mr_reload_done: got %b exp 1", a_done); end
    vectors++;
    if (a_wa.size() !== 1) begin
      errors++; $display("FAIL mr_count: got %0d writes exp 1", a_wa.size());
    end else begin
      vectors++; if (a_wa[0] !== 12'h000 || a_wd[0] !== 32'h12345678) begin
        errors++; $display("FAIL mr_write: got %h/%h exp 000/12345678", a_wa[0], a_wd[0]); end
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum_error();
    logic [7:0] bs [6] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
    start_load();
    foreach (bs[i]) send_byte(bs[i]);
    @(negedge clock);
    send_byte(8'hFF);
    vectors++; if (a_err !== 1'b1) begin errors++; $display("FAIL ck_err: got %b exp 1", a_err); end
    vectors++; if (a_done !== 1'b1) begin errors++; $display("FAIL ck_done: got %b exp 1", a_done); end
    repeat (3) @(negedge clock);
    vectors++; if (a_err !== 1'b1 || a_done !== 1'b1) begin
      errors++; $display("FAIL ck_hold: got err=%b done=%b exp 1/1", a_err, a_done); end
    start_load();
    vectors++; if (a_err !== 1'b0 || a_done !== 1'b0) begin
      errors++; $display("FAIL ck_clear: got err=%b done=%b exp 0/0", a_err, a_done); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    vectors++; if (a_err !== 1'b0 || a_done !== 1'b1) begin
      errors++; $display("FAIL ck_good: got err=%b done=%b exp 0/1", a_err, a_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_words();
    test_zero_header();
    test_backpressure();
    test_wrap();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum_error();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the pipelined processor. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory. While a load is in progress it holds the processor core so that nothing is fetched from a partially written image. It is the write-side counterpart of the register-checking bench flow, and lets a program be placed in imem at run time instead of through a memory-init file.

## Interface
- ADDR_WIDTH, 12: imem word-address width.
- BASE_ADDR, 0: first word address written by every load.
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- byte_in  in  8  stream byte.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer happens when byte_valid and byte_ready are both high.
- imem_address  out  ADDR_WIDTH  imem write address.
- imem_data  out  32  imem write data.
- imem_wren  out  1  imem write strobe, one cycle per word.
- cpu_hold  out  1  stalls the processor fetch stage and resets the PC to BASE_ADDR.
- load_done  out  1  load finished; stays high until the next load_start.
- load_error  out  1  checksum mismatch; only meaningful when the checksum feature is compiled in, otherwise tied to 0.

## Operation
- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE. CHECK exists only when the checksum feature is compiled in.
- IDLE/DONE: load_start moves to HDR_HI. On that move, clear load_done, clear load_error, and set the word address to BASE_ADDR.
- HDR_HI: one byte gives word_count[15:8]. HDR_LO: one byte gives word_count[7:0]. Only the low ADDR_WIDTH bits are kept.
- If the header word_count is 0, go from HDR_LO directly to CHECK, or to DONE when the feature is absent.
- DATA: accept 4 bytes. The first byte goes to bits [7:0] and the last to bits [31:24]. After the 4th byte, go to WRITE.
- WRITE: one cycle. imem_wren=1 with the assembled word and the current address. Then increment the address, decrement the remaining count, and go to DATA, or to CHECK/DONE if the count reaches 0.
- The address increments modulo 2^ADDR_WIDTH, so it wraps from 0xFFF to 0x000.
- byte_ready=1 only in HDR_HI, HDR_LO, DATA and CHECK. It is 0 in IDLE, WRITE and DONE.
- cpu_hold=1 in every state except IDLE and DONE.
- load_start is ignored outside IDLE and DONE.
- A byte presented while byte_ready=0 is not consumed. The source must hold it until a handshake occurs.

## Timing
- Reset values: state IDLE, byte_ready 0, imem_wren 0, imem_address BASE_ADDR, imem_data 0, cpu_hold 0, load_done 0, load_error 0.
- Reset asserted mid-load aborts the load immediately. Any partial word is discarded and no write is issued.
- load_start accepted at edge N: byte_ready=1 and cpu_hold=1 from cycle N+1.
- Throughput: each word takes 4 accepted bytes plus 1 WRITE cycle, i.e. a minimum of 5 cycles per word.
- imem_wren rises in the cycle after the edge on which the 4th byte handshakes.
- load_done rises in the cycle after the last WRITE, or after the CHECK handshake when the feature is present. cpu_hold falls in that same cycle.
- If load_start and byte_valid are high together in IDLE, no byte is consumed; byte_ready is 0 that cycle.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last word, CHECK accepts one byte.
  - load_error=1 when that byte differs from the XOR of all header and data bytes of the load.
  - DONE is entered regardless of the result; load_error is held until the next load_start.
- IMEM_LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no XOR register; load_error is constant 0.

## Structure
- Shared package processor_pkg holds:
  - the state enum type loader_state_t;
  - the constants IMEM_ADDR_WIDTH=12 and HDR_BYTES=2.
- One sub-module, byte_packer, shifts accepted bytes into the 32-bit word and counts bytes 0–3. Its outputs are word_ready and word.

## Test plan
- Load of 2 words: bytes 00 02 | 13 00 00 00 | 93 00 10 00.
  - Required: writes (0x000, 0x00000013) then (0x001, 0x00100093).
  - Required: load_done=1 and cpu_hold=0 two cycles after the last byte.
- Header 00 00: no imem_wren pulse; DONE is reached right after the header (after the checksum byte 00 when the feature is compiled in).
- Backpressure: byte_valid toggled 1/0 every cycle over a 1-word load with word 0xDEADBEEF.
  - Required: a single write of 0xDEADBEEF.
  - Required: byte_ready is 0 during the WRITE cycle and no byte is lost.
- Wrap: BASE_ADDR=0xFFF, 2-word load; the writes go to 0xFFF then 0x000.
- Reset asserted after 2 data bytes of the first word: no write occurs, all outputs return to their reset values, and a fresh load then succeeds.
- Checksum feature compiled in:
  - A correct XOR byte leaves load_error=0.
  - A corrupted XOR byte gives load_error=1 with load_done=1, and both remain until the next load_start.
